// File: rtl/tm_engine_core.sv
// Parametrised Turing machine core with a programmable rule table, single-step/free-run
// execution, step watchdog, fault reporting and a registered display read port.
module tm_engine_core #(
    parameter int unsigned SYM_W      = 4,
    parameter int unsigned TAPE_DEPTH = 64,
    parameter int unsigned NUM_STATES = 16,
    parameter int unsigned STEP_LIMIT = 1023,
    localparam int unsigned AW  = $clog2(TAPE_DEPTH),
    localparam int unsigned SW  = $clog2(NUM_STATES),
    localparam int unsigned CW  = $clog2(STEP_LIMIT + 1),
    localparam int unsigned RAW = SW + SYM_W,
    localparam int unsigned RDW = SW + SYM_W + 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             next_async,
    input  logic             done_async,
    input  logic [SYM_W-1:0] data_in,
    input  logic             step_mode,
    input  logic             rule_wr,
    input  logic [RAW-1:0]   rule_addr,
    input  logic [RDW-1:0]   rule_data,
    input  logic [AW-1:0]    disp_addr,
    output logic [SYM_W-1:0] disp_sym,
    output logic [AW-1:0]    head_pos,
    output logic [SW-1:0]    cur_state,
    output logic [CW-1:0]    step_count,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       fault
);

    localparam int unsigned RULES = 1 << RAW;

    localparam logic [1:0] MV_HALT  = 2'b00;
    localparam logic [1:0] MV_RIGHT = 2'b01;
    localparam logic [1:0] MV_LEFT  = 2'b10;

    typedef enum logic [1:0] {
        PH_LOAD   = 2'd0,
        PH_RUN    = 2'd1,
        PH_HALTED = 2'd2,
        PH_FAULT  = 2'd3
    } phase_e;

    phase_e           phase_q, phase_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    head_q, head_d;
    logic [SW-1:0]    state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       fault_q, fault_d;
    logic [SYM_W-1:0] disp_q, disp_d;

    logic [SYM_W-1:0] tape_q  [TAPE_DEPTH];
    logic [RDW-1:0]   rules_q [RULES];

    logic [1:0] next_s_q, done_s_q;
    logic       next_prev_q, done_prev_q;
    logic       next_p, done_p;

    logic             tape_we;
    logic [AW-1:0]    tape_waddr;
    logic [SYM_W-1:0] tape_wdata;
    logic             rule_we;
    logic             step_en;

    logic [SYM_W-1:0] rd_sym;
    logic [RDW-1:0]   rule_cur;
    logic [SW-1:0]    r_ns;
    logic [SYM_W-1:0] r_ws;
    logic [1:0]       r_mv;

    // Pulse is visible after the 2nd edge, so it acts on the 3rd edge after the pin rises
    assign next_p = next_s_q[1] & ~next_prev_q;
    assign done_p = done_s_q[1] & ~done_prev_q;

    assign rd_sym   = tape_q[head_q];
    assign rule_cur = rules_q[{state_q, rd_sym}];
    assign r_ns     = rule_cur[RDW-1 -: SW];
    assign r_ws     = rule_cur[2 +: SYM_W];
    assign r_mv     = rule_cur[1:0];
    assign step_en  = step_mode ? next_p : 1'b1;

    always_comb begin
        phase_d    = phase_q;
        wr_ptr_d   = wr_ptr_q;
        head_d     = head_q;
        state_d    = state_q;
        count_d    = count_q;
        fault_d    = fault_q;
        tape_we    = 1'b0;
        tape_waddr = head_q;
        tape_wdata = r_ws;
        rule_we    = 1'b0;
        disp_d     = '0;

        if ({1'b0, disp_addr} < (AW+1)'(TAPE_DEPTH)) begin
            disp_d = tape_q[disp_addr];
        end

        unique case (phase_q)
            PH_LOAD: begin
                rule_we = rule_wr && (32'(rule_addr[RAW-1:SYM_W]) < NUM_STATES);
                if (next_p && (wr_ptr_q < (AW+1)'(TAPE_DEPTH))) begin
                    tape_we    = 1'b1;
                    tape_waddr = wr_ptr_q[AW-1:0];
                    tape_wdata = data_in;
                    wr_ptr_d   = wr_ptr_q + (AW+1)'(1);
                end
                if (done_p) begin
                    phase_d = PH_RUN;
                    head_d  = '0;
                    state_d = '0;
                    count_d = '0;
                end
            end
            PH_RUN: begin
                if (done_p) begin
                    phase_d = PH_HALTED;
                    fault_d = 2'b00;
                end else if (step_en) begin
                    // Faulting steps commit nothing: tape, state, head and count hold
                    if (count_q == CW'(STEP_LIMIT)) begin
                        phase_d = PH_FAULT;
                        fault_d = 2'b11;
                    end else if (r_mv == MV_LEFT && head_q == '0) begin
                        phase_d = PH_FAULT;
                        fault_d = 2'b01;
                    end else if (r_mv == MV_RIGHT && head_q == AW'(TAPE_DEPTH - 1)) begin
                        phase_d = PH_FAULT;
                        fault_d = 2'b10;
                    end else begin
                        tape_we = 1'b1;
                        state_d = r_ns;
                        count_d = count_q + CW'(1);
                        if (r_mv == MV_RIGHT) begin
                            head_d = head_q + AW'(1);
                        end else if (r_mv == MV_LEFT) begin
                            head_d = head_q - AW'(1);
                        end
                        if (r_mv == MV_HALT) begin
                            phase_d = PH_HALTED;
                        end
                    end
                end
            end
            PH_HALTED, PH_FAULT: begin
                if (done_p) begin
                    phase_d  = PH_LOAD;
                    wr_ptr_d = '0;
                    fault_d  = 2'b00;
                    count_d  = '0;
                end
            end
            default: phase_d = PH_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q     <= PH_LOAD;
            wr_ptr_q    <= '0;
            head_q      <= '0;
            state_q     <= '0;
            count_q     <= '0;
            fault_q     <= '0;
            disp_q      <= '0;
            next_s_q    <= '0;
            done_s_q    <= '0;
            next_prev_q <= 1'b0;
            done_prev_q <= 1'b0;
            for (int i = 0; i < int'(TAPE_DEPTH); i++) begin
                tape_q[i] <= '0;
            end
            for (int i = 0; i < int'(RULES); i++) begin
                rules_q[i] <= '0;
            end
        end else begin
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            head_q      <= head_d;
            state_q     <= state_d;
            count_q     <= count_d;
            fault_q     <= fault_d;
            disp_q      <= disp_d;
            next_s_q    <= {next_s_q[0], next_async};
            done_s_q    <= {done_s_q[0], done_async};
            next_prev_q <= next_s_q[1];
            done_prev_q <= done_s_q[1];
            if (tape_we) begin
                tape_q[tape_waddr] <= tape_wdata;
            end
            if (rule_we) begin
                rules_q[rule_addr] <= rule_data;
            end
        end
    end

    assign disp_sym   = disp_q;
    assign head_pos   = head_q;
    assign cur_state  = state_q;
    assign step_count = count_q;
    assign fault      = fault_q;
    assign busy       = (phase_q == PH_RUN);
    assign halted     = (phase_q == PH_HALTED);

endmodule

// File: tb/tb_tm_engine_core.sv
// Directed bench for tm_engine_core: single-rule scenario table plus hand-written
// sequences for synchroniser timing, unary increment, single-step, overflow and reset.
module tb_tm_engine_core;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       next_async, done_async;
    logic [3:0] data_in;
    logic       step_mode, rule_wr;
    logic [7:0] rule_addr;
    logic [9:0] rule_data;
    logic [5:0] disp_addr;
    logic [3:0] disp_sym;
    logic [5:0] head_pos;
    logic [3:0] cur_state;
    logic [9:0] step_count;
    logic       busy, halted;
    logic [1:0] fault;

    int checks = 0;
    int errors = 0;

    tm_engine_core dut (
        .clock(clock), .reset_n(reset_n), .next_async(next_async), .done_async(done_async),
        .data_in(data_in), .step_mode(step_mode), .rule_wr(rule_wr), .rule_addr(rule_addr),
        .rule_data(rule_data), .disp_addr(disp_addr), .disp_sym(disp_sym), .head_pos(head_pos),
        .cur_state(cur_state), .step_count(step_count), .busy(busy), .halted(halted),
        .fault(fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] ns;
        logic [3:0] ws;
        logic [1:0] mv;
        logic [5:0] e_head;
        logic [9:0] e_cnt;
        logic [3:0] e_state;
        logic [1:0] e_fault;
        logic       e_halted;
        logic [3:0] e_tape0;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic pulse_next(input logic [3:0] d);
        data_in    = d;
        next_async = 1'b1;
        repeat (4) tick();
        next_async = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_done();
        done_async = 1'b1;
        repeat (4) tick();
        done_async = 1'b0;
        repeat (3) tick();
    endtask

    task automatic write_rule(input logic [3:0] st, input logic [3:0] sym,
                              input logic [3:0] ns, input logic [3:0] ws, input logic [1:0] mv);
        rule_addr = {st, sym};
        rule_data = {ns, ws, mv};
        rule_wr   = 1'b1;
        tick();
        rule_wr   = 1'b0;
    endtask

    task automatic read_tape(input logic [5:0] a, output logic [3:0] v);
        disp_addr = a;
        tick();
        v = disp_sym;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    logic [3:0] v;

    initial begin
        reset_n = 1'b0; next_async = 1'b0; done_async = 1'b0; data_in = '0;
        step_mode = 1'b0; rule_wr = 1'b0; rule_addr = '0; rule_data = '0; disp_addr = '0;

        vecs[0] = '{ns: 4'd0, ws: 4'd0, mv: 2'b10, e_head: 6'd0,  e_cnt: 10'd0,
                    e_state: 4'd0, e_fault: 2'b01, e_halted: 1'b0, e_tape0: 4'd0};
        vecs[1] = '{ns: 4'd0, ws: 4'd0, mv: 2'b01, e_head: 6'd63, e_cnt: 10'd63,
                    e_state: 4'd0, e_fault: 2'b10, e_halted: 1'b0, e_tape0: 4'd0};
        vecs[2] = '{ns: 4'd0, ws: 4'd0, mv: 2'b11, e_head: 6'd0,  e_cnt: 10'd1023,
                    e_state: 4'd0, e_fault: 2'b11, e_halted: 1'b0, e_tape0: 4'd0};
        vecs[3] = '{ns: 4'd3, ws: 4'd7, mv: 2'b00, e_head: 6'd0,  e_cnt: 10'd1,
                    e_state: 4'd3, e_fault: 2'b00, e_halted: 1'b1, e_tape0: 4'd7};

        // Reset state
        do_reset();
        check("rst_head", head_pos, 0);
        check("rst_state", cur_state, 0);
        check("rst_count", step_count, 0);
        check("rst_fault", fault, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_disp", disp_sym, 0);

        // Synchroniser timing: write lands on edge 3, disp_sym shows it one edge later
        disp_addr  = 6'd0;
        data_in    = 4'd5;
        next_async = 1'b1;
        repeat (3) tick();
        check("sync_edge3_disp", disp_sym, 0);
        tick();
        check("sync_edge4_disp", disp_sym, 5);
        repeat (6) tick();
        next_async = 1'b0;
        repeat (3) tick();
        read_tape(6'd1, v);
        check("sync_single_write", v, 0);
        pulse_next(4'd9);
        read_tape(6'd1, v);
        check("sync_wrptr1", v, 9);
        read_tape(6'd0, v);
        check("sync_tape0", v, 5);

        // Single-rule scenarios on a zero tape
        for (int i = 0; i < 4; i++) begin
            do_reset();
            step_mode = 1'b0;
            write_rule(4'd0, 4'd0, vecs[i].ns, vecs[i].ws, vecs[i].mv);
            pulse_done();
            wait_idle($sformatf("v%0d_idle", i), 2000);
            check($sformatf("v%0d_head", i), head_pos, vecs[i].e_head);
            check($sformatf("v%0d_count", i), step_count, vecs[i].e_cnt);
            check($sformatf("v%0d_state", i), cur_state, vecs[i].e_state);
            check($sformatf("v%0d_fault", i), fault, vecs[i].e_fault);
            check($sformatf("v%0d_halted", i), halted, vecs[i].e_halted);
            read_tape(6'd0, v);
            check($sformatf("v%0d_tape0", i), v, vecs[i].e_tape0);
        end

        // Unary increment, free-run
        do_reset();
        write_rule(4'd0, 4'd1, 4'd0, 4'd1, 2'b01);
        write_rule(4'd0, 4'd0, 4'd1, 4'd1, 2'b00);
        for (int i = 0; i < 3; i++) pulse_next(4'd1);
        step_mode = 1'b0;
        pulse_done();
        wait_idle("inc_idle", 100);
        check("inc_halted", halted, 1);
        check("inc_head", head_pos, 3);
        check("inc_count", step_count, 4);
        check("inc_state", cur_state, 1);
        check("inc_fault", fault, 0);
        for (int i = 0; i < 5; i++) begin
            read_tape(6'(i), v);
            check($sformatf("inc_tape%0d", i), v, (i < 4) ? 1 : 0);
        end

        // Single-step, ignored rule write in RUN, abort and return to LOAD
        do_reset();
        write_rule(4'd0, 4'd1, 4'd0, 4'd1, 2'b01);
        write_rule(4'd0, 4'd0, 4'd1, 4'd1, 2'b00);
        for (int i = 0; i < 3; i++) pulse_next(4'd1);
        step_mode = 1'b1;
        pulse_done();
        check("ss_busy", busy, 1);
        check("ss_count0", step_count, 0);
        pulse_next(4'd0);
        pulse_next(4'd0);
        check("ss_head", head_pos, 2);
        check("ss_count", step_count, 2);
        write_rule(4'd0, 4'd1, 4'd5, 4'd9, 2'b11);
        tick();
        check("ss_hold_count", step_count, 2);
        pulse_done();
        check("ss_abort_halted", halted, 1);
        check("ss_abort_count", step_count, 2);
        check("ss_abort_fault", fault, 0);
        pulse_done();
        check("ss_load_halted", halted, 0);
        check("ss_load_busy", busy, 0);
        check("ss_load_count", step_count, 0);
        for (int i = 0; i < 3; i++) begin
            read_tape(6'(i), v);
            check($sformatf("ss_tape%0d", i), v, 1);
        end
        step_mode = 1'b0;
        pulse_done();
        wait_idle("ss_rerun_idle", 100);
        check("ss_rerun_halted", halted, 1);
        check("ss_rerun_count", step_count, 4);
        check("ss_rerun_state", cur_state, 1);
        read_tape(6'd0, v);
        check("ss_rerun_tape0", v, 1);

        // 65 Next edges in LOAD: only 64 writes
        do_reset();
        for (int i = 0; i < 65; i++) pulse_next(4'(i % 15 + 1));
        read_tape(6'd0, v);
        check("ovf_tape0", v, 1);
        read_tape(6'd1, v);
        check("ovf_tape1", v, 2);
        read_tape(6'd63, v);
        check("ovf_tape63", v, 4);

        // Reset in the middle of a run
        do_reset();
        write_rule(4'd0, 4'd0, 4'd0, 4'd0, 2'b11);
        pulse_next(4'd0);
        pulse_next(4'd7);
        pulse_done();
        repeat (20) tick();
        check("mid_busy", busy, 1);
        check("mid_count_nz", (step_count != 0), 1);
        disp_addr = 6'd1;
        reset_n   = 1'b0;
        tick();
        reset_n   = 1'b1;
        check("mrst_busy", busy, 0);
        check("mrst_halted", halted, 0);
        check("mrst_count", step_count, 0);
        check("mrst_head", head_pos, 0);
        check("mrst_fault", fault, 0);
        check("mrst_disp", disp_sym, 0);
        read_tape(6'd1, v);
        check("mrst_tape1", v, 0);
        pulse_next(4'd4);
        read_tape(6'd0, v);
        check("mrst_load_tape0", v, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tm_engine_core.md
Name: tm_engine_core

Overview:
- Parametrised successor to the fixed 4-bit/64-cell Turing machine core.
- Adds the following:
  - run-time programmable rule table;
  - configurable symbol width, tape depth and state count;
  - free-run or single-step mode;
  - step-limit watchdog;
  - fault reporting;
  - an independent display read port.
- Contains its own input synchronisers and edge detectors, so the chip top wires raw pins directly.

Parameters:
SYM_W, 4, tape symbol width in bits
TAPE_DEPTH, 64, number of tape cells (>=2); AW = clog2(TAPE_DEPTH)
NUM_STATES, 16, machine states; SW = clog2(NUM_STATES)
STEP_LIMIT, 1023, maximum executed steps before watchdog fault; CW = clog2(STEP_LIMIT+1)

Ports:
clock  in  1  single clock
reset_n  in  1  synchronous, active-low reset
next_async  in  1  raw "Next" pin
done_async  in  1  raw "Done" pin
data_in  in  SYM_W  tape symbol to load
step_mode  in  1  1 = single-step on Next edge; 0 = one step per cycle
rule_wr  in  1  rule write strobe, one entry per cycle
rule_addr  in  SW+SYM_W  {state, read_symbol}
rule_data  in  SW+SYM_W+2  {next_state, write_symbol, move[1:0]}
disp_addr  in  AW  display read address
disp_sym  out  SYM_W  tape[disp_addr], registered
head_pos  out  AW  current head index
cur_state  out  SW  current machine state
step_count  out  CW  number of committed steps
busy  out  1  phase == RUN
halted  out  1  phase == HALTED
fault  out  2  00 none, 01 left edge, 10 right edge, 11 watchdog

Behaviour:
- Reset (reset_n low at clock edge):
  - phase = LOAD; wr_ptr, head_pos, cur_state, step_count, fault, disp_sym = 0.
  - Every tape cell = 0.
  - Every rule = 0. Move code 00 = HALT, so an unprogrammed rule halts.
  - Synchroniser and edge flops = 0.
  - Reset mid-RUN aborts immediately, with no further write.
- Input conditioning:
  - Each async pin passes through 2 flops, then a rising-edge detect flop.
  - A one-cycle pulse (next_p / done_p) asserts on the 3rd clock edge after the pin rises.
  - Holding a pin high produces exactly one pulse.
- Move encoding: 00 HALT, 01 RIGHT (+1), 10 LEFT (-1), 11 STAY.
- Rule writes:
  - Accepted only in LOAD; table[rule_addr] <= rule_data on the same edge.
  - Ignored in other phases.
  - rule_addr with state >= NUM_STATES is ignored.
- LOAD phase:
  - next_p: tape[wr_ptr] <= data_in, wr_ptr++.
  - When wr_ptr == TAPE_DEPTH, next_p is ignored. There is no wrap, and the tape keeps its contents.
  - done_p: phase <= RUN; head_pos, cur_state, step_count <= 0.
  - Simultaneous next_p and done_p: the write is performed, then RUN is entered.
- RUN phase:
  - Step enable: every cycle when step_mode = 0; next_p when step_mode = 1.
  - step_mode is sampled every cycle and may change mid-run.
  - A step looks up r = table[{cur_state, tape[head_pos]}]; lookup is combinational, one step per cycle.
  - Watchdog precedes the step: if step_count == STEP_LIMIT, phase <= FAULT, fault = 11, nothing committed.
  - LEFT at head 0 → FAULT 01; RIGHT at TAPE_DEPTH-1 → FAULT 10. The faulting step is not committed: no write, and state, head and count are unchanged.
  - Otherwise:
    - tape[head] <= write_symbol;
    - cur_state <= next_state;
    - head moves per code;
    - step_count++.
  - If the move is HALT, the same commit occurs with head unchanged, then phase <= HALTED.
  - done_p in RUN aborts to HALTED with fault = 00 and no step in that cycle. done_p has priority over a step.
- HALTED / FAULT phases:
  - Outputs hold.
  - done_p → LOAD: wr_ptr <= 0, fault <= 00, step_count <= 0. Tape and rules are retained.
  - next_p is ignored.
- Display port:
  - disp_sym <= tape[disp_addr] every cycle, in all phases, with 1-cycle latency.
  - The value reflects tape contents before any write made on the same edge.
  - disp_addr >= TAPE_DEPTH returns 0.

Test Plan:
- Sync/edge: hold next_async high for 10 cycles in LOAD with data_in = 5 → exactly one write, tape[0] = 5 visible on disp_sym, wr_ptr = 1; the pulse lands on the 3rd edge after the rise.
- Unary increment:
  - Rules: (0,1)→(0,1,RIGHT); (0,0)→(1,1,HALT).
  - Load tape 1,1,1, then Done, with step_mode = 0.
  - Required: tape = 1,1,1,1; halted = 1; head_pos = 3; step_count = 4; cur_state = 1; fault = 00.
- Boundaries:
  - Rule (0,0)→(0,0,LEFT) on a zero tape → fault = 01 after 0 steps, tape unchanged.
  - Rule (0,0)→(0,0,RIGHT) with TAPE_DEPTH = 64 → fault = 10 with head_pos = 63 and step_count = 63.
- Watchdog: STEP_LIMIT = 1023 with rule (0,0)→(0,0,STAY) → fault = 11, step_count = 1023, busy low.
- Single-step and abort:
  - step_mode = 1 with the increment program → one step per Next edge; after 2 edges, head_pos = 2 and step_count = 2.
  - Done then gives halted = 1 with step_count = 2.
  - A second Done returns to LOAD with the tape retained.
- Reset/overflow:
  - 65 Next edges in LOAD → only 64 writes, tape[0] intact.
  - reset_n low mid-RUN → all outputs and tape 0, phase = LOAD.
  - Rule writes during RUN have no effect.
